// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the pipelined ALU: the 3-bit function-code type
//   and one named constant per operation. Imported by alu_core and alu_pipe.
package alu_pkg;

  typedef logic [2:0] fxn_t;

  localparam fxn_t FXN_PASS_X = 3'b000;
  localparam fxn_t FXN_PASS_Y = 3'b001;
  localparam fxn_t FXN_NEG_X  = 3'b010;
  localparam fxn_t FXN_NEG_Y  = 3'b011;
  localparam fxn_t FXN_CMP_GE = 3'b100;
  localparam fxn_t FXN_XOR    = 3'b101;
  localparam fxn_t FXN_ADD    = 3'b110;
  localparam fxn_t FXN_SUB    = 3'b111;

endpackage

// File: rtl/alu_core.sv
// alu_core
//   Purely combinational ALU datapath, split in two halves so the pipeline
//   register can sit at the adder output.
//   Front half (x, y, fxn -> sum, carry_msb, ge):
//     one shared WIDTH+1-bit adder with operand inversion / carry-in
//     selection, plus the signed x >= y compare.
//   Back half (s_* inputs -> result, overflow, c_out):
//     final result mux and flag generation from the registered front-half
//     values.
//   Ports:
//     x, y, fxn          front-half operands and operation code
//     sum                WIDTH+1-bit adder sum (bit WIDTH is the carry out)
//     carry_msb          carry into the MSB of the adder
//     ge                 signed x >= y
//     s_x, s_y, s_fxn    registered operands and code for the back half
//     s_sum, s_carry_msb, s_ge   registered front-half results
//     result, overflow, c_out    final outputs
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  fxn_t             fxn,
  output logic [WIDTH:0]   sum,
  output logic             carry_msb,
  output logic             ge,
  input  logic [WIDTH-1:0] s_x,
  input  logic [WIDTH-1:0] s_y,
  input  fxn_t             s_fxn,
  input  logic [WIDTH:0]   s_sum,
  input  logic             s_carry_msb,
  input  logic             s_ge,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             c_out
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;

  // Steer the operands of the single shared adder. Negation is 0 + ~v + 1
  // and subtraction is x + ~y + 1, so only operand A zeroing, operand B
  // inversion and the carry-in change between the arithmetic codes.
  always_comb begin
    op_a = x;
    op_b = y;
    cin  = 1'b0;
    case (fxn)
      FXN_NEG_X: begin
        op_a = '0;
        op_b = ~x;
        cin  = 1'b1;
      end
      FXN_NEG_Y: begin
        op_a = '0;
        op_b = ~y;
        cin  = 1'b1;
      end
      FXN_SUB: begin
        op_b = ~y;
        cin  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};

  // The MSB sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out
  // of the full sum without a second, narrower adder.
  assign carry_msb = sum[WIDTH-1] ^ op_a[WIDTH-1] ^ op_b[WIDTH-1];

  assign ge = $signed(x) >= $signed(y);

  // Final mux. Only the adder-based codes report carry and overflow; the
  // pass, compare and XOR codes force both flags low.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    c_out    = 1'b0;
    case (s_fxn)
      FXN_PASS_X: result = s_x;
      FXN_PASS_Y: result = s_y;
      FXN_CMP_GE: result = {{(WIDTH-1){1'b0}}, s_ge};
      FXN_XOR:    result = s_x ^ s_y;
      default: begin
        result   = s_sum[WIDTH-1:0];
        c_out    = s_sum[WIDTH];
        overflow = s_carry_msb ^ s_sum[WIDTH];
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe
//   Two-stage pipelined WIDTH-bit ALU with valid/ready handshakes on both
//   sides and a sticky overflow status bit.
//   S1 holds the operands, the shared adder sum, its carries and the compare
//   result; S2 holds the final result and flags presented to the sink.
//   Ports:
//     clk, reset            clock (rising edge), async active-high reset
//     in_valid / in_ready   operand-side handshake
//     x, y, fxn             operands and operation code
//     out_valid / out_ready result-side handshake
//     result, overflow, c_out  result beat and its flags
//     clr_sticky            clears sticky_ovf (a simultaneous set wins)
//     sticky_ovf            set once an overflowed result is delivered
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       fxn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             c_out,
  input  logic             clr_sticky,
  output logic             sticky_ovf
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  fxn_t             s1_fxn_q, s1_fxn_d;
  logic [WIDTH:0]   s1_sum_q, s1_sum_d;
  logic             s1_carry_msb_q, s1_carry_msb_d;
  logic             s1_ge_q, s1_ge_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             c_out_q, c_out_d;
  logic             sticky_q, sticky_d;

  logic [WIDTH:0]   core_sum;
  logic             core_carry_msb;
  logic             core_ge;
  logic [WIDTH-1:0] core_result;
  logic             core_overflow;
  logic             core_c_out;

  logic             s2_load;
  logic             in_xfer;
  logic             out_xfer;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .x          (x),
    .y          (y),
    .fxn        (fxn),
    .sum        (core_sum),
    .carry_msb  (core_carry_msb),
    .ge         (core_ge),
    .s_x        (s1_x_q),
    .s_y        (s1_y_q),
    .s_fxn      (s1_fxn_q),
    .s_sum      (s1_sum_q),
    .s_carry_msb(s1_carry_msb_q),
    .s_ge       (s1_ge_q),
    .result     (core_result),
    .overflow   (core_overflow),
    .c_out      (core_c_out)
  );

  // Handshake decode. S2 takes a beat from S1 when it is empty or its
  // current beat is leaving this edge; S1 can then refill on the same edge,
  // so a draining pipeline never inserts a bubble.
  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    in_xfer  = in_valid && in_ready;
    out_xfer = s2_valid_q && out_ready;
  end

  // Next-state for S1: capture the operands and the front-half ALU results
  // on an input transfer, otherwise hold; the valid bit clears when the beat
  // moves on to S2 without a replacement arriving.
  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_x_d         = s1_x_q;
    s1_y_d         = s1_y_q;
    s1_fxn_d       = s1_fxn_q;
    s1_sum_d       = s1_sum_q;
    s1_carry_msb_d = s1_carry_msb_q;
    s1_ge_d        = s1_ge_q;
    if (in_xfer) begin
      s1_valid_d     = 1'b1;
      s1_x_d         = x;
      s1_y_d         = y;
      s1_fxn_d       = fxn;
      s1_sum_d       = core_sum;
      s1_carry_msb_d = core_carry_msb;
      s1_ge_d        = core_ge;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Next-state for S2 and the sticky bit. The result registers only change
  // on a load, which keeps them stable through any sink stall. The sticky
  // set has priority over a clear in the same cycle.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    c_out_d    = c_out_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      result_d   = core_result;
      overflow_d = core_overflow;
      c_out_d    = core_c_out;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    sticky_d = sticky_q;
    if (out_xfer && overflow_q) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  // All pipeline state, including data, clears on reset so nothing from an
  // interrupted stream can reappear once reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s1_x_q         <= '0;
      s1_y_q         <= '0;
      s1_fxn_q       <= FXN_PASS_X;
      s1_sum_q       <= '0;
      s1_carry_msb_q <= 1'b0;
      s1_ge_q        <= 1'b0;
      s2_valid_q     <= 1'b0;
      result_q       <= '0;
      overflow_q     <= 1'b0;
      c_out_q        <= 1'b0;
      sticky_q       <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_x_q         <= s1_x_d;
      s1_y_q         <= s1_y_d;
      s1_fxn_q       <= s1_fxn_d;
      s1_sum_q       <= s1_sum_d;
      s1_carry_msb_q <= s1_carry_msb_d;
      s1_ge_q        <= s1_ge_d;
      s2_valid_q     <= s2_valid_d;
      result_q       <= result_d;
      overflow_q     <= overflow_d;
      c_out_q        <= c_out_d;
      sticky_q       <= sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign result     = result_q;
  assign overflow   = overflow_q;
  assign c_out      = c_out_q;
  assign sticky_ovf = sticky_q;

endmodule
